// File: rtl/calc_link_pkg.sv
// Shared definitions for the calculator serial link: frame field layout,
// default widths and the receive-side FSM encoding.
package calc_link_pkg;

    localparam int DATA_SIZE = 32;
    localparam int OP_WIDTH  = 8;
    localparam int FIELD_W   = 4;

    // Frame layout, MSB first on the wire: {OpA, OpB, AluRes, Sel, Flags}
    localparam int OPA_MSB = 31;
    localparam int OPB_MSB = 23;
    localparam int RES_MSB = 15;
    localparam int SEL_MSB = 7;
    localparam int FLG_MSB = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        TAIL = 2'd2
    } rx_state_e;

endpackage

// File: rtl/calc_frame_receiver_if.sv
// Serial link pins plus the unpacked-frame/handshake side of the receiver.
interface calc_frame_receiver_if
    import calc_link_pkg::*;
#(
    parameter int DataSize = DATA_SIZE,
    parameter int OpWidth  = OP_WIDTH
);
    logic                ClkTx;
    logic                DoutValid;
    logic                DataOut;
    logic                FrameAck;
    logic [DataSize-1:0] Frame;
    logic [OpWidth-1:0]  OpA;
    logic [OpWidth-1:0]  OpB;
    logic [OpWidth-1:0]  AluRes;
    logic [FIELD_W-1:0]  SelOut;
    logic [FIELD_W-1:0]  FlagsOut;
    logic                FrameValid;
    logic                RxBusy;
    logic                ErrShort;
    logic                ErrOverrun;
    logic                ErrOverflow;

    // Transmitter / consumer side
    modport master (
        output ClkTx, DoutValid, DataOut, FrameAck,
        input  Frame, OpA, OpB, AluRes, SelOut, FlagsOut,
        input  FrameValid, RxBusy, ErrShort, ErrOverrun, ErrOverflow
    );

    // Receiver side
    modport slave (
        input  ClkTx, DoutValid, DataOut, FrameAck,
        output Frame, OpA, OpB, AluRes, SelOut, FlagsOut,
        output FrameValid, RxBusy, ErrShort, ErrOverrun, ErrOverflow
    );
endinterface

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for one asynchronous input, with a registered
// level and a rising-edge pulse that are aligned to each other.
module sync_edge_det #(
    parameter int SyncStages = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise
);
    logic [SyncStages-1:0] sync_q, sync_d;
    logic                  level_q, level_d;
    logic                  rise_q, rise_d;

    always_comb begin
        sync_d  = {sync_q[SyncStages-2:0], din};
        level_d = sync_q[SyncStages-1];
        rise_d  = sync_q[SyncStages-1] & ~level_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            level_q <= level_d;
            rise_q  <= rise_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
endmodule

// File: rtl/calc_frame_receiver.sv
// Deserializes the MSB-first result frame from the calculator link, unpacks
// its fields and holds it for a consumer under a valid/ack handshake.
module calc_frame_receiver
    import calc_link_pkg::*;
#(
    parameter int DataSize   = DATA_SIZE,
    parameter int OpWidth    = OP_WIDTH,
    parameter int SyncStages = 2
) (
    input  logic                  Clk,
    input  logic                  Reset,
    calc_frame_receiver_if.slave  rx
);
    localparam int CNT_W = $clog2(DataSize) + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DataSize);

    logic clk_rise, dv_lvl, dv_rise, data_lvl;
    logic unused_clk_lvl, unused_data_rise;

    // DataOut goes through the same depth as ClkTx so the sampled bit lines
    // up with the detected edge.
    sync_edge_det #(.SyncStages(SyncStages)) u_sync_clk (
        .clk(Clk), .rst(Reset), .din(rx.ClkTx),
        .level(unused_clk_lvl), .rise(clk_rise)
    );
    sync_edge_det #(.SyncStages(SyncStages)) u_sync_dv (
        .clk(Clk), .rst(Reset), .din(rx.DoutValid),
        .level(dv_lvl), .rise(dv_rise)
    );
    sync_edge_det #(.SyncStages(SyncStages)) u_sync_data (
        .clk(Clk), .rst(Reset), .din(rx.DataOut),
        .level(data_lvl), .rise(unused_data_rise)
    );

    rx_state_e           state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DataSize-1:0] sr_q, sr_d;
    logic [DataSize-1:0] frame_q, frame_d;
    logic                frame_valid_q, frame_valid_d;
    logic                err_short_q, err_short_d;
    logic                err_overrun_q, err_overrun_d;
    logic                err_overflow_q, err_overflow_d;
    logic                complete;

    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        sr_d           = sr_q;
        frame_d        = frame_q;
        frame_valid_d  = frame_valid_q;
        err_short_d    = 1'b0;
        err_overrun_d  = 1'b0;
        err_overflow_d = 1'b0;
        complete       = 1'b0;

        // The ack frees the buffer before any completion in the same cycle.
        if (rx.FrameAck) frame_valid_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (dv_rise) begin
                    state_d = RECV;
                    cnt_d   = '0;
                end
            end
            RECV: begin
                if (clk_rise) begin
                    sr_d  = {sr_q[DataSize-2:0], data_lvl};
                    cnt_d = cnt_q + CNT_W'(1);
                end
                // An edge coinciding with the envelope fall is counted first.
                if (cnt_d == CNT_FULL) begin
                    complete = 1'b1;
                    state_d  = dv_lvl ? TAIL : IDLE;
                end else if (!dv_lvl) begin
                    err_short_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            TAIL: begin
                if (clk_rise) err_overrun_d = 1'b1;
                if (!dv_lvl)  state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (complete) begin
            if (frame_valid_d) begin
                err_overflow_d = 1'b1;
            end else begin
                frame_d       = sr_d;
                frame_valid_d = 1'b1;
            end
        end
    end

    // NOTE: reset is synchronous; it discards any partial frame and
    // suppresses the error pulses for that cycle.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            sr_q           <= '0;
            frame_q        <= '0;
            frame_valid_q  <= 1'b0;
            err_short_q    <= 1'b0;
            err_overrun_q  <= 1'b0;
            err_overflow_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            sr_q           <= sr_d;
            frame_q        <= frame_d;
            frame_valid_q  <= frame_valid_d;
            err_short_q    <= err_short_d;
            err_overrun_q  <= err_overrun_d;
            err_overflow_q <= err_overflow_d;
        end
    end

    assign rx.Frame       = frame_q;
    assign rx.OpA         = frame_q[OPA_MSB -: OpWidth];
    assign rx.OpB         = frame_q[OPB_MSB -: OpWidth];
    assign rx.AluRes      = frame_q[RES_MSB -: OpWidth];
    assign rx.SelOut      = frame_q[SEL_MSB -: FIELD_W];
    assign rx.FlagsOut    = frame_q[FLG_MSB -: FIELD_W];
    assign rx.FrameValid  = frame_valid_q;
    assign rx.RxBusy      = (state_q == RECV);
    assign rx.ErrShort    = err_short_q;
    assign rx.ErrOverrun  = err_overrun_q;
    assign rx.ErrOverflow = err_overflow_q;
endmodule

// File: tb/tb_calc_frame_receiver.sv
// Directed bench for calc_frame_receiver: table of nominal frames plus
// hand-written sequences for short, overrun, overflow, reset and loopback.
module tb_calc_frame_receiver;
    import calc_link_pkg::*;

    localparam int SYNC = 2;
    localparam int LAT  = SYNC + 2;

    logic Clk = 1'b0;
    logic Reset;

    calc_frame_receiver_if #(.DataSize(32), .OpWidth(8)) bus ();

    calc_frame_receiver #(.DataSize(32), .OpWidth(8), .SyncStages(SYNC)) dut (
        .Clk(Clk), .Reset(Reset), .rx(bus.slave)
    );

    always #5 Clk = ~Clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_short = 0, n_overrun = 0, n_overflow = 0;
    logic fv_prev = 1'b0;
    time fv_time = 0, edge_time = 0;

    typedef struct {
        logic [31:0] word;
        logic [7:0]  opa, opb, res;
        logic [3:0]  sel, flg;
    } vec_t;

    vec_t vecs[3];

    always @(negedge Clk) begin
        if (bus.ErrShort)    n_short++;
        if (bus.ErrOverrun)  n_overrun++;
        if (bus.ErrOverflow) n_overflow++;
        if (bus.FrameValid && !fv_prev) fv_time = $time;
        fv_prev = bus.FrameValid;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, limit %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int k);
        repeat (k) @(posedge Clk);
        #1;
    endtask

    task automatic clear_counts();
        n_short = 0;
        n_overrun = 0;
        n_overflow = 0;
    endtask

    // Sends w[nbits-1:0] MSB first with ClkTx = Clk/4. Optionally holds
    // FrameAck high in the cycle the 32nd edge completes the frame.
    task automatic send(input logic [63:0] w, input int nbits,
                        input bit close_env, input bit ack_at_end);
        int n = 0;
        bus.DoutValid = 1'b1;
        bus.ClkTx     = 1'b0;
        cyc(2);
        for (int i = nbits - 1; i >= 0; i--) begin
            bus.ClkTx   = 1'b0;
            bus.DataOut = w[i];
            cyc(2);
            bus.ClkTx = 1'b1;
            n++;
            if (n == 32) begin
                edge_time = $time;
                if (ack_at_end) begin
                    cyc(LAT - 1);
                    bus.FrameAck = 1'b1;
                    cyc(1);
                    bus.FrameAck = 1'b0;
                end else begin
                    cyc(2);
                end
            end else begin
                cyc(2);
            end
        end
        if (close_env) begin
            bus.ClkTx = 1'b0;
            cyc(2);
            bus.DoutValid = 1'b0;
            cyc(8);
        end
    endtask

    task automatic ack_frame(input string name);
        bus.FrameAck = 1'b1;
        cyc(1);
        bus.FrameAck = 1'b0;
        @(negedge Clk);
        check(name, bus.FrameValid, 1'b0);
        cyc(1);
    endtask

    logic [7:0] la, lb, lres;
    logic [8:0] lsum;
    logic [3:0] lsel, lflg;

    initial begin
        vecs[0] = '{word: 32'hA53CE195, opa: 8'hA5, opb: 8'h3C, res: 8'hE1, sel: 4'h9, flg: 4'h5};
        vecs[1] = '{word: 32'hDEADBEEF, opa: 8'hDE, opb: 8'hAD, res: 8'hBE, sel: 4'hE, flg: 4'hF};
        vecs[2] = '{word: 32'h12345678, opa: 8'h12, opb: 8'h34, res: 8'h56, sel: 4'h7, flg: 4'h8};

        Reset = 1'b1;
        bus.ClkTx = 1'b0;
        bus.DoutValid = 1'b0;
        bus.DataOut = 1'b0;
        bus.FrameAck = 1'b0;
        cyc(3);
        @(negedge Clk);
        check("reset_outputs", {bus.Frame, bus.FrameValid, bus.RxBusy, bus.ErrShort,
                                bus.ErrOverrun, bus.ErrOverflow}, '0);
        cyc(1);
        Reset = 1'b0;
        cyc(4);

        // Nominal frames from the table
        for (int v = 0; v < 3; v++) begin
            clear_counts();
            send({32'h0, vecs[v].word}, 32, 1'b1, 1'b0);
            @(negedge Clk);
            check($sformatf("v%0d_latency", v), 64'((fv_time - edge_time) / 10), 64'(LAT));
            check($sformatf("v%0d_valid", v), bus.FrameValid, 1'b1);
            check($sformatf("v%0d_frame", v), bus.Frame, vecs[v].word);
            check($sformatf("v%0d_fields", v), {bus.OpA, bus.OpB, bus.AluRes, bus.SelOut, bus.FlagsOut},
                  {vecs[v].opa, vecs[v].opb, vecs[v].res, vecs[v].sel, vecs[v].flg});
            check($sformatf("v%0d_errs", v), {n_short, n_overrun, n_overflow}, '0);
            cyc(1);
            ack_frame($sformatf("v%0d_ack_clears", v));
        end

        // Short frame, then a full frame recovers
        clear_counts();
        send(64'hABCDE, 20, 1'b1, 1'b0);
        @(negedge Clk);
        check("short_pulse_count", n_short, 1);
        check("short_no_valid", bus.FrameValid, 1'b0);
        cyc(1);
        send(64'h1, 32, 1'b1, 1'b0);
        @(negedge Clk);
        check("after_short_frame", {bus.FrameValid, bus.Frame}, {1'b1, 32'h00000001});
        check("after_short_flags", bus.FlagsOut, 4'h1);
        cyc(1);
        ack_frame("after_short_ack");

        // 34 edges in one envelope
        clear_counts();
        send({30'h0, 32'hFFFF0000, 2'b11}, 34, 1'b1, 1'b0);
        @(negedge Clk);
        check("overrun_frame", {bus.FrameValid, bus.Frame}, {1'b1, 32'hFFFF0000});
        check("overrun_pulses", n_overrun, 2);
        check("overrun_no_short", n_short, 0);
        cyc(1);
        ack_frame("overrun_ack");

        // Back-to-back without ack: second frame dropped
        clear_counts();
        send(64'h11111111, 32, 1'b1, 1'b0);
        send(64'h22222222, 32, 1'b1, 1'b0);
        @(negedge Clk);
        check("overflow_frame_kept", bus.Frame, 32'h11111111);
        check("overflow_pulses", n_overflow, 1);
        cyc(1);
        ack_frame("overflow_ack");

        // Same pair with ack in the completion cycle: second frame loads
        clear_counts();
        send(64'h11111111, 32, 1'b1, 1'b0);
        send(64'h22222222, 32, 1'b1, 1'b1);
        @(negedge Clk);
        check("ack_same_cycle_frame", {bus.FrameValid, bus.Frame}, {1'b1, 32'h22222222});
        check("ack_same_cycle_no_ovf", n_overflow, 0);

        // Reset mid-frame at bit 16 with a held frame still valid
        cyc(1);
        clear_counts();
        send(64'hDEAD, 16, 1'b0, 1'b0);
        @(negedge Clk);
        check("mid_frame_busy", bus.RxBusy, 1'b1);
        @(posedge Clk);
        #1;
        Reset = 1'b1;
        bus.DoutValid = 1'b0;
        bus.ClkTx = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        check("mid_reset_outputs", {bus.Frame, bus.FrameValid, bus.RxBusy, bus.ErrShort,
                                    bus.ErrOverrun, bus.ErrOverflow}, '0);
        #1;
        Reset = 1'b0;
        cyc(8);
        check("mid_reset_no_err", {n_short, n_overrun, n_overflow}, '0);
        send(64'hDEADBEEF, 32, 1'b1, 1'b0);
        @(negedge Clk);
        check("post_reset_frame", {bus.FrameValid, bus.Frame}, {1'b1, 32'hDEADBEEF});
        check("post_reset_no_err", {n_short, n_overrun, n_overflow}, '0);
        cyc(1);
        ack_frame("post_reset_ack");

        // Loopback: bench model of the transmitter, A + B with select 1,
        // flags = {overflow, negative, zero, carry}
        la   = 8'd200;
        lb   = 8'd100;
        lsel = 4'h1;
        lsum = {1'b0, la} + {1'b0, lb};
        lres = lsum[7:0];
        lflg = {(la[7] == lb[7]) && (lres[7] != la[7]), lres[7], lres == 8'd0, lsum[8]};
        send({32'h0, la, lb, lres, lsel, lflg}, 32, 1'b1, 1'b0);
        @(negedge Clk);
        check("loop_alures", bus.AluRes, 8'd44);
        check("loop_carry", bus.FlagsOut[0], 1'b1);
        check("loop_flags", bus.FlagsOut, 4'b0001);
        check("loop_ops", {bus.OpA, bus.OpB, bus.SelOut}, {8'd200, 8'd100, 4'h1});
        cyc(1);
        ack_frame("loop_ack");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/calc_frame_receiver.md
Name: calc_frame_receiver

Overview:
- Receive end of the calculator serial link: deserializes the 32-bit result frame driven on DataOut/ClkTx/DoutValid back into a parallel word.
- Unpacks the word into operand A, operand B, ALU result, selector and flags.
- Holds each received frame for a consumer under a valid/ack handshake.
- Sits on the board side or in the testbench loopback, clocked by the system Clk; ClkTx is treated as a data signal and oversampled.

Parameters:
DataSize, 32, frame width in bits; must equal 2*OpWidth + ResWidth + 2*4 (default 8+8+8+4+4).
OpWidth, 8, width of operand A, operand B and ALU result fields.
SyncStages, 2, synchronizer flops on ClkTx, DoutValid and DataOut (minimum 2).

Ports:
Clk  in  1  system clock; all logic on its rising edge
Reset  in  1  synchronous, active-high reset
ClkTx  in  1  serial bit clock from transmitter (asynchronous to Clk, at most Clk/4)
DoutValid  in  1  frame envelope; high for the whole frame
DataOut  in  1  serial data, MSB first, stable around ClkTx rising edge
FrameAck  in  1  consumer accepts the held frame
Frame  out  DataSize  last accepted frame
OpA  out  OpWidth  Frame[31:24]
OpB  out  OpWidth  Frame[23:16]
AluRes  out  OpWidth  Frame[15:8]
SelOut  out  4  Frame[7:4]
FlagsOut  out  4  Frame[3:0]
FrameValid  out  1  held frame not yet acknowledged
RxBusy  out  1  reception in progress (state RECV)
ErrShort  out  1  one-cycle pulse: DoutValid fell before DataSize bits
ErrOverrun  out  1  one-cycle pulse: extra ClkTx edge after DataSize bits
ErrOverflow  out  1  one-cycle pulse: frame completed while FrameValid high; new frame dropped

Behaviour:
- All three serial inputs pass through identical SyncStages-deep synchronizers, so the sampled bit stays aligned with the detected edge.
- Rising-edge detect is done on the synchronized ClkTx.
- Reset: all outputs 0, shift register 0, bit counter 0, state IDLE. Reset overrides everything, including mid-frame; any partial frame is discarded and no error pulse is emitted.
- FSM states: IDLE, RECV, TAIL.
  - IDLE: on synchronized DoutValid rising, enter RECV with counter = 0.
  - IDLE: ClkTx edges while DoutValid is low are ignored.
  - RECV: on each ClkTx rising edge, shift register <= {sr[DataSize-2:0], DataOut_sync} and counter++.
  - RECV: the cycle the counter reaches DataSize, perform the frame completion step and go to TAIL.
  - RECV: DoutValid falls with counter < DataSize → pulse ErrShort, discard, go to IDLE.
  - RECV: if an edge and a DoutValid fall occur in the same cycle, the edge is counted first. If that edge completes the frame, the frame is accepted and the FSM goes directly to IDLE.
  - TAIL: each further ClkTx rising edge pulses ErrOverrun; data is ignored.
  - TAIL: DoutValid low → IDLE.
- Frame completion step:
  - If FrameValid = 0: Frame <= shifted word and FrameValid <= 1, both in the cycle after the 32nd edge is detected.
  - If FrameValid = 1: Frame is unchanged and ErrOverflow pulses.
- Handshake:
  - FrameValid clears in the cycle after FrameAck = 1 is sampled.
  - If FrameAck and a completion occur in the same cycle, the ack frees the buffer first and the new frame loads. FrameValid stays 1 and there is no overflow.
  - FrameAck while FrameValid = 0 is ignored.
- Field outputs are pure slices of the Frame register, so they carry no extra latency.
- Latency: last ClkTx rising edge at the pin → FrameValid high after SyncStages+2 Clk cycles.
- Counter width is clog2(DataSize)+1; it never wraps, because the FSM leaves RECV at DataSize.

Decomposition:
- Shared package calc_link_pkg holds:
  - Frame field offsets/widths: OPA_MSB=31, OPB_MSB=23, RES_MSB=15, SEL_MSB=7, FLG_MSB=3.
  - DataSize default.
  - FSM state encoding: IDLE=2'd0, RECV=2'd1, TAIL=2'd2.
  - The same offsets are used by the transmit-side concatenation.
- Sub-module sync_edge_det (SyncStages parameter): synchronizes one input and produces the synchronized level plus a rising-edge pulse. It is instantiated for ClkTx and DoutValid; DataOut uses the level-only path.

Test Plan:
- Nominal frame 32'hA5_3C_E1_95 (OpA=A5, OpB=3C, Res=E1, Sel=9, Flags=5), ClkTx=Clk/4, MSB first → FrameValid after SyncStages+2 cycles; fields match. FrameAck → FrameValid=0 next cycle.
- DoutValid dropped after 20 bits → ErrShort single pulse, FrameValid stays 0. The next full frame 32'h0000_0001 is received correctly.
- 34 ClkTx edges inside one envelope carrying 32'hFFFF_0000 → frame = FFFF0000 accepted and exactly 2 ErrOverrun pulses.
- Two back-to-back frames 32'h11111111 then 32'h22222222, no ack → Frame stays 11111111 and one ErrOverflow pulse. Repeat with FrameAck in the completion cycle → Frame = 22222222, no overflow.
- Reset asserted at bit 16 of a frame → all outputs 0 the next cycle, no error pulse. The following frame 32'hDEADBEEF is received intact.
- Loopback against the transmitter with ALU inputs A=8'd200, B=8'd100, add selector → AluRes and FlagsOut equal the ALU outputs (result 8'd44, carry flag set).
